rf80386_ifetch_buf: RTL and testbench
=====================================

Name: rf80386_ifetch_buf

Overview:
- Instruction fetch line buffer directly upstream of the rf80386 core.
- Takes the core's csip and returns a 128-bit byte-aligned instruction bundle plus a hit flag.
- Holds two 16-byte code lines and fills misses over a simple tagged read channel to the bus interface.
- The core stalls, counting imiss, while ihit is low.

Parameters:
- RTY_WAIT, 5'd8: idle cycles between a retry response and the reissued request.
- CORENO, 6'd1: core number driven on mem_tid.core.
- CID, 3'd1: channel driven on mem_tid.channel.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- csip  in  32  linear fetch address from the core.
- flush_i  in  1  invalidate both lines (far jump, mode change, code write).
- ibundle  out  128  16 bytes starting at csip; byte 0 is in bits [7:0].
- ihit  out  1  ibundle is valid this cycle.
- mem_req  out  1  read request strobe, held until acked or retried.
- mem_adr  out  32  line address, always {line[27:0],4'h0}.
- mem_tid  out  13  {core[5:0],channel[2:0],tranid[3:0]}.
- mem_ack  in  1  response valid.
- mem_rty  in  1  retry response.
- mem_rtid  in  4  tranid of the response.
- mem_dat  in  128  line data.
- miss_o  out  1  one-cycle pulse when a fill request is first issued.

Behaviour:
- Storage: slots S0 and S1, each with data[127:0], tag[27:0] and valid.
- Line addresses: A = csip[31:4]; B = A+1, which wraps 28'hFFFFFFF to 0.
- Needed lines: A only when csip[3:0]==0; otherwise both A and B.
- ihit is combinational: 1 when every needed line is valid in some slot and flush_i is 0.
- ibundle is combinational: the low 128 bits of {dataB,dataA} >> (csip[3:0]*8). It is don't-care when ihit is 0.
- Outputs at reset: valid=0 for both slots, ihit=0, mem_req=0, mem_adr=0, tranid=1, miss_o=0. FSM is in IDLE.
- State IDLE:
  - If ihit=0 and flush_i=0, pick fill line F: A if A is absent, else B.
  - Pick victim slot: the slot not holding the other needed line. If neither slot holds it, use S0.
  - Latch F and the victim. Drive mem_req=1 and mem_adr={F,4'h0}. Increment tranid, wrapping 15 to 1 (0 is never used). Pulse miss_o. Go to WAIT.
- State WAIT:
  - mem_req stays high with stable mem_adr and mem_tid until a response arrives.
  - Responses whose mem_rtid does not equal the current tranid are ignored.
  - mem_ack with matching tid: write mem_dat into the victim slot, set tag=F and valid=1, drop mem_req, go to IDLE. ihit can rise on the next cycle, so minimum miss latency is 2 cycles plus bus latency.
  - mem_rty with matching tid: drop mem_req, load the wait counter with RTY_WAIT, go to RWAIT.
  - If mem_ack and mem_rty are both asserted, ack wins.
- State RWAIT: count down to 0, then reissue the same address with a new tranid and go to WAIT. miss_o does not pulse on a reissue.
- flush_i:
  - Clears both valids in the same cycle. It takes priority over a fill write in that cycle.
  - In WAIT or RWAIT, sets a drop flag. The pending response is consumed without writing a slot, then the FSM returns to IDLE. A new miss is issued from IDLE on the following cycle.
  - flush_i in IDLE suppresses issuing a request that cycle.
- csip changing while in WAIT: the fill completes to the latched F regardless. ihit is re-evaluated against the new csip.
- Reset asserted mid-operation: all state clears asynchronously; mem_req drops immediately.

Optional Feature:
- Macro: RF80386_IBUF_PREFETCH_EN.
- When defined: in IDLE with ihit=1, csip[3:0]==0 and B absent, issue a fill of B into the slot not holding A. miss_o does not pulse for this prefetch.
  - A prefetch in flight that no longer matches the needed lines still completes.
  - It is written only if its victim slot does not hold a currently needed line; otherwise it is dropped.
- When not defined: no requests are issued while ihit=1.

Test Plan:
- Reset, then csip=32'h000F0000 -> ihit=0, miss_o pulse, mem_adr=32'h000F0000, tranid=2. Ack with data 16'h00..0F bytes -> next cycle ihit=1, ibundle[7:0]=8'h00.
- csip=32'h000F0005 with only line 0xF000 valid -> fill of 32'h000F0010. After ack, ibundle[7:0]=byte 5 of line 0 and ibundle[127:88]=bytes 0..4 of line 1.
- Retry: mem_rty with matching tid -> mem_req low for exactly RTY_WAIT=8 cycles, then reissue of the same address with tranid incremented and no miss_o.
- Stale response: mem_ack with mem_rtid=tranid-1 during WAIT -> ignored, no slot write, mem_req stays high.
- flush_i during WAIT, then matching ack -> no slot valid, ihit stays 0, new request issued the cycle after the ack.
- tranid wrap: issue 15 misses -> the sequence runs ...,14,15,1 and never 0. With PREFETCH_EN, csip=32'h00001000 hit -> request for 32'h00001010 issued with no miss_o.

Source files
------------

// File: rtl/rf80386_ifetch_buf_if.sv
// Tagged line-read channel between the rf80386 fetch buffer (master) and the bus interface (slave).
interface rf80386_ifetch_buf_if;
  logic         mem_req;
  logic [31:0]  mem_adr;
  logic [12:0]  mem_tid;
  logic         mem_ack;
  logic         mem_rty;
  logic [3:0]   mem_rtid;
  logic [127:0] mem_dat;

  modport master (
    output mem_req, mem_adr, mem_tid,
    input  mem_ack, mem_rty, mem_rtid, mem_dat
  );

  modport slave (
    input  mem_req, mem_adr, mem_tid,
    output mem_ack, mem_rty, mem_rtid, mem_dat
  );
endinterface

// File: rtl/rf80386_ifetch_buf.sv
// rf80386 instruction fetch line buffer: two 16-byte code lines refilled over a tagged read channel.
// Optional RF80386_IBUF_PREFETCH_EN: prefetch the sequential line on aligned hits.
module rf80386_ifetch_buf #(
  parameter logic [4:0] RTY_WAIT = 5'd8,
  parameter logic [5:0] CORENO   = 6'd1,
  parameter logic [2:0] CID      = 3'd1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [31:0]                 csip,
  input  logic                        flush_i,
  output logic [127:0]                ibundle,
  output logic                        ihit,
  output logic                        miss_o,
  rf80386_ifetch_buf_if.master        mem
);

  // state | meaning
  // IDLE  | serve csip from the slots; issue a fill when a needed line is absent
  // WAIT  | request outstanding; wait for ack/retry carrying the current tranid
  // RWAIT | back-off after a retry before reissuing the same line
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RWAIT} state_t;

  state_t         state_q;
  logic [127:0]   data0_q, data1_q;
  logic [27:0]    tag0_q, tag1_q, fill_q;
  logic           vld0_q, vld1_q, victim_q, drop_q, req_q;
  logic [31:0]    adr_q;
  logic [3:0]     tranid_q, tid_next;
  logic [4:0]     cnt_q;

  logic [27:0]    line_a, line_b, fill_f, issue_line;
  logic           need_b, a_in0, a_in1, b_in0, b_in1, a_hit, b_hit;
  logic           miss_go, pf_go, pf_block, victim_miss, ack_hit, rty_hit, fill_wr;
  logic [127:0]   data_a, data_b;

  assign line_a = csip[31:4];
  assign line_b = line_a + 28'd1;
  assign need_b = |csip[3:0];

  assign a_in0 = vld0_q && (tag0_q == line_a);
  assign a_in1 = vld1_q && (tag1_q == line_a);
  assign b_in0 = vld0_q && (tag0_q == line_b);
  assign b_in1 = vld1_q && (tag1_q == line_b);
  assign a_hit = a_in0 || a_in1;
  assign b_hit = b_in0 || b_in1;

  assign ihit    = a_hit && (!need_b || b_hit) && !flush_i;
  assign data_a  = a_in0 ? data0_q : data1_q;
  assign data_b  = b_in0 ? data0_q : data1_q;
  assign ibundle = 128'({data_b, data_a} >> {csip[3:0], 3'b000});

  assign miss_go = !ihit && !flush_i;
  assign fill_f  = a_hit ? line_b : line_a;
  // Victim is whichever slot does not hold the other needed line; S0 when neither does.
  assign victim_miss = a_hit ? a_in0 : (need_b && b_in0);
  assign issue_line  = miss_go ? fill_f : line_b;
  assign tid_next    = (tranid_q == 4'd15) ? 4'd1 : tranid_q + 4'd1;

  assign ack_hit = mem.mem_ack && (mem.mem_rtid == tranid_q);
  assign rty_hit = mem.mem_rty && (mem.mem_rtid == tranid_q);
  assign fill_wr = ack_hit && !drop_q && !flush_i && !pf_block;

  assign mem.mem_req = req_q;
  assign mem.mem_adr = adr_q;
  assign mem.mem_tid = {CORENO, CID, tranid_q};

`ifdef RF80386_IBUF_PREFETCH_EN
  logic pf_q, vic_needed;

  assign pf_go      = ihit && !need_b && !b_hit;
  assign vic_needed = victim_q ? (a_in1 || (need_b && b_in1)) : (a_in0 || (need_b && b_in0));
  // A prefetch never evicts a line the core currently needs.
  assign pf_block   = pf_q && vic_needed;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pf_q <= 1'b0;
    end else if (state_q == S_IDLE && (miss_go || pf_go)) begin
      pf_q <= pf_go;
    end
  end
`else
  assign pf_go    = 1'b0;
  assign pf_block = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      data0_q  <= '0;
      data1_q  <= '0;
      tag0_q   <= '0;
      tag1_q   <= '0;
      vld0_q   <= 1'b0;
      vld1_q   <= 1'b0;
      fill_q   <= '0;
      victim_q <= 1'b0;
      drop_q   <= 1'b0;
      req_q    <= 1'b0;
      adr_q    <= '0;
      tranid_q <= 4'd1;
      cnt_q    <= '0;
      miss_o   <= 1'b0;
    end else begin
      miss_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (miss_go || pf_go) begin
            fill_q   <= issue_line;
            victim_q <= miss_go ? victim_miss : a_in0;
            miss_o   <= miss_go;
            req_q    <= 1'b1;
            adr_q    <= {issue_line, 4'h0};
            tranid_q <= tid_next;
            state_q  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush_i) drop_q <= 1'b1;
          if (ack_hit) begin
            if (fill_wr) begin
              if (victim_q) begin
                data1_q <= mem.mem_dat;
                tag1_q  <= fill_q;
                vld1_q  <= 1'b1;
              end else begin
                data0_q <= mem.mem_dat;
                tag0_q  <= fill_q;
                vld0_q  <= 1'b1;
              end
            end
            req_q   <= 1'b0;
            drop_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (rty_hit) begin
            req_q <= 1'b0;
            if (drop_q || flush_i) begin
              drop_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              cnt_q   <= (RTY_WAIT == 5'd0) ? 5'd0 : RTY_WAIT - 5'd1;
              state_q <= S_RWAIT;
            end
          end
        end
        S_RWAIT: begin
          if (drop_q || flush_i) begin
            drop_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (cnt_q == 5'd0) begin
            req_q    <= 1'b1;
            tranid_q <= tid_next;
            state_q  <= S_WAIT;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // Flush wins over a fill write landing in the same cycle.
      if (flush_i) begin
        vld0_q <= 1'b0;
        vld1_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rf80386_ifetch_buf.sv
// Scoreboard bench for rf80386_ifetch_buf: requests and hit bundles are checked by a monitor against queued expectations.
module tb_rf80386_ifetch_buf;
  logic         clk;
  logic         rst_n;
  logic [31:0]  csip;
  logic         flush_i;
  logic [127:0] ibundle;
  logic         ihit;
  logic         miss_o;

  rf80386_ifetch_buf_if mem_if ();

  rf80386_ifetch_buf dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .csip    (csip),
    .flush_i (flush_i),
    .ibundle (ibundle),
    .ihit    (ihit),
    .miss_o  (miss_o),
    .mem     (mem_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic [3:0]  tid;
    logic        miss;
  } req_t;

  req_t         req_q [$];
  logic [127:0] bund_q [$];
  int           total = 0;
  int           bad   = 0;
  logic [3:0]   etid;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] line_dat(input logic [27:0] l);
    logic [127:0] d;
    for (int i = 0; i < 16; i++) d[i*8 +: 8] = {l[3:0], 4'(i)};
    return d;
  endfunction

  function automatic logic [127:0] exp_bund(input logic [31:0] c);
    logic [127:0] d;
    logic [27:0]  l;
    int           off;
    for (int k = 0; k < 16; k++) begin
      off = int'(c[3:0]) + k;
      l   = (off < 16) ? c[31:4] : c[31:4] + 28'd1;
      d[k*8 +: 8] = {l[3:0], 4'(off)};
    end
    return d;
  endfunction

  function automatic logic [3:0] nxt(input logic [3:0] t);
    return (t == 4'd15) ? 4'd1 : t + 4'd1;
  endfunction

  task automatic push_req(input logic [31:0] adr, input logic [3:0] tid, input logic miss);
    req_t r;
    r.adr = adr; r.tid = tid; r.miss = miss;
    req_q.push_back(r);
  endtask

  task automatic set_csip(input logic [31:0] v);
    @(posedge clk); #1;
    csip = v;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_if.mem_req) return;
    end
    total++; bad++;
    $display("FAIL req_timeout actual=no_request required=mem_req");
  endtask

  task automatic respond(input logic ack, input logic rty, input logic [3:0] tid, input logic [127:0] dat);
    @(posedge clk); #1;
    mem_if.mem_ack = ack; mem_if.mem_rty = rty; mem_if.mem_rtid = tid; mem_if.mem_dat = dat;
    @(posedge clk); #1;
    mem_if.mem_ack = 1'b0; mem_if.mem_rty = 1'b0; mem_if.mem_rtid = 4'd0; mem_if.mem_dat = '0;
    @(negedge clk);
  endtask

  task automatic fill_line(input logic [27:0] l);
    etid = nxt(etid);
    push_req({l, 4'h0}, etid, 1'b1);
    set_csip({l, 4'h0});
    wait_req();
    bund_q.push_back(exp_bund({l, 4'h0}));
    respond(1'b1, 1'b0, etid, line_dat(l));
  endtask

  // Monitor: a new request or a fresh hit pops the matching expectation.
  logic        prev_req = 1'b0;
  logic [12:0] prev_tid = '0;
  logic        prev_hit = 1'b0;
  logic [31:0] prev_csip = '0;
  always @(negedge clk) begin
    req_t r;
    if (rst_n) begin
      if (mem_if.mem_req && (!prev_req || mem_if.mem_tid != prev_tid)) begin
        if (req_q.size() == 0) begin
          total++; bad++;
          $display("FAIL req_unexpected actual=%h required=none", mem_if.mem_adr);
        end else begin
          r = req_q.pop_front();
          chk("req_adr", 128'(mem_if.mem_adr), 128'(r.adr));
          chk("req_tranid", 128'(mem_if.mem_tid[3:0]), 128'(r.tid));
          chk("req_core_ch", 128'(mem_if.mem_tid[12:4]), 128'({6'd1, 3'd1}));
          chk("req_miss_o", 128'(miss_o), 128'(r.miss));
        end
      end
      if (ihit && (!prev_hit || csip != prev_csip)) begin
        if (bund_q.size() == 0) begin
          total++; bad++;
          $display("FAIL hit_unexpected actual=%h required=none", csip);
        end else begin
          chk("ibundle", ibundle, bund_q.pop_front());
        end
      end
    end
    prev_req  = mem_if.mem_req;
    prev_tid  = mem_if.mem_tid;
    prev_hit  = ihit;
    prev_csip = csip;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_n = 1'b0;
    csip = 32'h000F0000;
    flush_i = 1'b0;
    mem_if.mem_ack = 1'b0; mem_if.mem_rty = 1'b0; mem_if.mem_rtid = 4'd0; mem_if.mem_dat = '0;
    etid = 4'd1;
    repeat (3) @(negedge clk);
    chk("rst_ihit", 128'(ihit), 128'(0));
    chk("rst_mem_req", 128'(mem_if.mem_req), 128'(0));
    chk("rst_mem_adr", 128'(mem_if.mem_adr), 128'(0));
    chk("rst_tid", 128'(mem_if.mem_tid), 128'({6'd1, 3'd1, 4'd1}));
    chk("rst_miss_o", 128'(miss_o), 128'(0));

    // First miss on aligned line 0xF000
    etid = nxt(etid);
    push_req(32'h000F0000, etid, 1'b1);
    @(posedge clk); #1; rst_n = 1'b1;
    wait_req();
    chk("miss_ihit_low", 128'(ihit), 128'(0));
    bund_q.push_back(exp_bund(32'h000F0000));
    respond(1'b1, 1'b0, etid, line_dat(28'h000F000));

    // Unaligned csip needs the following line too
    etid = nxt(etid);
    push_req(32'h000F0010, etid, 1'b1);
    set_csip(32'h000F0005);
    wait_req();
    bund_q.push_back(exp_bund(32'h000F0005));
    respond(1'b1, 1'b0, etid, line_dat(28'h000F001));

    // Retry then reissue after the back-off
    etid = nxt(etid);
    push_req(32'h000F0020, etid, 1'b1);
    set_csip(32'h000F0020);
    wait_req();
    push_req(32'h000F0020, nxt(etid), 1'b0);
    respond(1'b0, 1'b1, etid, '0);
    etid = nxt(etid);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (mem_if.mem_req) break;
      cnt++;
      @(negedge clk);
    end
    chk("rty_gap", 128'(cnt), 128'(8));
    bund_q.push_back(exp_bund(32'h000F0020));
    respond(1'b1, 1'b0, etid, line_dat(28'h000F002));

    // Stale ack must be ignored
    etid = nxt(etid);
    push_req(32'h000F0030, etid, 1'b1);
    set_csip(32'h000F0030);
    wait_req();
    respond(1'b1, 1'b0, etid - 4'd1, ~line_dat(28'h000F003));
    chk("stale_req_held", 128'(mem_if.mem_req), 128'(1));
    chk("stale_ihit", 128'(ihit), 128'(0));
    bund_q.push_back(exp_bund(32'h000F0030));
    respond(1'b1, 1'b0, etid, line_dat(28'h000F003));

    // Flush while waiting: response dropped, new miss the cycle after
    etid = nxt(etid);
    push_req(32'h000F0040, etid, 1'b1);
    set_csip(32'h000F0040);
    wait_req();
    @(posedge clk); #1; flush_i = 1'b1;
    @(posedge clk); #1; flush_i = 1'b0;
    push_req(32'h000F0040, nxt(etid), 1'b1);
    respond(1'b1, 1'b0, etid, line_dat(28'h000F004));
    etid = nxt(etid);
    chk("flush_req_low", 128'(mem_if.mem_req), 128'(0));
    chk("flush_ihit", 128'(ihit), 128'(0));
    @(negedge clk);
    chk("flush_reissue", 128'(mem_if.mem_req), 128'(1));
    bund_q.push_back(exp_bund(32'h000F0040));
    respond(1'b1, 1'b0, etid, line_dat(28'h000F004));

    // Tranid runs through 15 and wraps to 1
    for (int i = 0; i < 10; i++) fill_line(28'h000F005 + 28'(i));

    // Line address wrap: B of 0xFFFFFFF is line 0
    etid = nxt(etid);
    push_req(32'hFFFFFFF0, etid, 1'b1);
    push_req(32'h00000000, nxt(etid), 1'b1);
    set_csip(32'hFFFFFFF8);
    wait_req();
    respond(1'b1, 1'b0, etid, line_dat(28'hFFFFFFF));
    etid = nxt(etid);
    wait_req();
    bund_q.push_back(exp_bund(32'hFFFFFFF8));
    respond(1'b1, 1'b0, etid, line_dat(28'h0000000));

    repeat (5) @(negedge clk);
    chk("req_q_drained", 128'(req_q.size()), 128'(0));
    chk("bund_q_drained", 128'(bund_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
